// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
// Grant-source encoding and default widths used by the arbiter and bench.
package wb_port_arbiter_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned ZERO_REG   = 0;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_FIFO = 2'd2,
        GNT_BYP  = 2'd3
    } gnt_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous result FIFO with occupancy count, sync active-low reset.
// A push while full is ignored even if a pop happens in the same cycle.
module wb_result_fifo #(
    parameter int unsigned W     = 37,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign count   = cnt;

    // Storage array: written on accepted push, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered mul/div.
// Optional same-cycle bypass of multi-cycle results: define WB_BYPASS_EN.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4,
    localparam int unsigned CW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regwrite_mem_wb,
    input  logic              MemtoReg_mem_wb,
    input  logic [DATA_W-1:0] read_data_mem_wb,
    input  logic [DATA_W-1:0] result_mem_wb,
    input  logic [ADDR_W-1:0] Reg_dest_op_mem_wb,
    input  logic              mc_valid,
    input  logic [DATA_W-1:0] mc_data,
    input  logic [ADDR_W-1:0] mc_dest,
    output logic              mc_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pipe_stall,
    output logic [CW-1:0]     fifo_count,
    output logic              protocol_err
);

    localparam int unsigned EW    = ADDR_W + DATA_W;
    localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 1);

    logic [EW-1:0]     fifo_dout;
    logic [ADDR_W-1:0] head_dest;
    logic [DATA_W-1:0] head_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    gnt_t              gnt;
    logic              forced;
    logic [AGE_W-1:0]  age;
    logic              armed;
    logic              stall_fire;

    assign head_dest = fifo_dout[EW-1:DATA_W];
    assign head_data = fifo_dout[DATA_W-1:0];

    assign mc_ready   = reset && !fifo_full;
    assign fifo_pop   = reset && (gnt == GNT_FIFO);
    assign fifo_push  = mc_valid && mc_ready && (gnt != GNT_BYP);
    assign stall_fire = armed && !fifo_empty
                      && (age == AGE_W'(STARVE_LIMIT));

    wb_result_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({mc_dest, mc_data}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Pick the write-port owner: forced FIFO, pipeline, idle-slot FIFO.
    always_comb begin
        gnt = GNT_NONE;
        if (forced && !fifo_empty) begin
            gnt = GNT_FIFO;
        end else if (regwrite_mem_wb) begin
            gnt = GNT_PIPE;
        end else if (!fifo_empty) begin
            gnt = GNT_FIFO;
        end
`ifdef WB_BYPASS_EN
        else if (mc_valid) begin
            gnt = GNT_BYP;
        end
`endif
    end

    // Route the winner onto the write port; r0 writes are suppressed.
    always_comb begin
        rf_waddr = '0;
        rf_wdata = '0;
        unique case (gnt)
            GNT_PIPE: begin
                rf_waddr = Reg_dest_op_mem_wb;
                rf_wdata = MemtoReg_mem_wb ? read_data_mem_wb
                                           : result_mem_wb;
            end
            GNT_FIFO: begin
                rf_waddr = head_dest;
                rf_wdata = head_data;
            end
            GNT_BYP: begin
                rf_waddr = mc_dest;
                rf_wdata = mc_data;
            end
            default: begin
                rf_waddr = '0;
                rf_wdata = '0;
            end
        endcase
        rf_we = reset && (gnt != GNT_NONE)
              && (rf_waddr != ADDR_W'(ZERO_REG));
    end

    // Head age, one-shot bubble request, forced grant and error pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            age          <= '0;
            armed        <= 1'b1;
            pipe_stall   <= 1'b0;
            forced       <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            pipe_stall   <= stall_fire;
            forced       <= pipe_stall;
            protocol_err <= forced && !fifo_empty && regwrite_mem_wb;
            if (fifo_empty || fifo_pop) begin
                age   <= '0;
                armed <= 1'b1;
            end else begin
                if (age != AGE_W'(STARVE_LIMIT)) begin
                    age <= age + AGE_W'(1);
                end
                if (stall_fire) begin
                    armed <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: queue-based reference model,
// directed scenarios with literal expectations, then random traffic.
module tb_wb_port_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int LIM   = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          rw;
    logic          m2r;
    logic [DW-1:0] rdat;
    logic [DW-1:0] res;
    logic [AW-1:0] pdst;
    logic          mcv;
    logic [DW-1:0] mcd;
    logic [AW-1:0] mcdst;
    logic          mc_ready;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          pipe_stall;
    logic [CW-1:0] fifo_count;
    logic          protocol_err;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .DATA_W       (DW),
        .ADDR_W       (AW),
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .regwrite_mem_wb    (rw),
        .MemtoReg_mem_wb    (m2r),
        .read_data_mem_wb   (rdat),
        .result_mem_wb      (res),
        .Reg_dest_op_mem_wb (pdst),
        .mc_valid           (mcv),
        .mc_data            (mcd),
        .mc_dest            (mcdst),
        .mc_ready           (mc_ready),
        .rf_we              (rf_we),
        .rf_waddr           (rf_waddr),
        .rf_wdata           (rf_wdata),
        .pipe_stall         (pipe_stall),
        .fifo_count         (fifo_count),
        .protocol_err       (protocol_err)
    );

    typedef struct {
        logic [AW-1:0] dst;
        logic [DW-1:0] val;
    } ent_t;

    // reference model: pending results, how long the head has waited,
    // whether the head already got its bubble, and the 1-cycle flags
    ent_t q[$];
    int   head_wait   = 0;
    bit   bubble_used = 0;
    bit   m_stall     = 0;
    bit   m_forced    = 0;
    bit   m_perr      = 0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pw(input logic w, input logic m, input logic [DW-1:0] rd,
                      input logic [DW-1:0] rs, input logic [AW-1:0] d);
        rw = w; m2r = m; rdat = rd; res = rs; pdst = d;
    endtask

    task automatic mc(input logic v, input logic [DW-1:0] d,
                      input logic [AW-1:0] a);
        mcv = v; mcd = d; mcdst = a;
    endtask

    // compare this cycle's outputs with the model, then advance the model
    task automatic run();
        bit            empty;
        bit            fifo_turn;
        bit            pop;
        bit            byp;
        bit            e_we;
        bit            e_rdy;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        @(negedge clk);
        empty     = (q.size() == 0);
        fifo_turn = m_forced && !empty;
        pop = 0; byp = 0; ea = '0; ed = '0;
        if (fifo_turn || (!rw && !empty)) begin
            pop = 1; ea = q[0].dst; ed = q[0].val;
        end else if (rw) begin
            ea = pdst; ed = m2r ? rdat : res;
        end
`ifdef WB_BYPASS_EN
        else if (mcv) begin
            byp = 1; ea = mcdst; ed = mcd;
        end
`endif
        e_we  = reset && (pop || rw || byp) && (ea != 0);
        e_rdy = reset && (q.size() < DEPTH);
        chk("rf_we", {31'd0, rf_we}, {31'd0, e_we});
        if (e_we) begin
            chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, ea});
            chk("rf_wdata", rf_wdata, ed);
        end
        chk("mc_ready", {31'd0, mc_ready}, {31'd0, e_rdy});
        chk("fifo_count", 32'(fifo_count), 32'(q.size()));
        chk("pipe_stall", {31'd0, pipe_stall}, {31'd0, m_stall});
        chk("protocol_err", {31'd0, protocol_err}, {31'd0, m_perr});
        if (!reset) begin
            q.delete();
            head_wait = 0; bubble_used = 0;
            m_stall = 0; m_forced = 0; m_perr = 0;
        end else begin
            m_forced = m_stall;
            m_stall  = !empty && !bubble_used && (head_wait >= LIM);
            m_perr   = fifo_turn && rw;
            if (empty || pop) begin
                head_wait = 0; bubble_used = 0;
            end else begin
                head_wait++;
                if (m_stall) bubble_used = 1;
            end
            if (pop) void'(q.pop_front());
            if (mcv && e_rdy && !byp) q.push_back('{dst: mcdst, val: mcd});
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0;
        pw(0, 0, 0, 0, 0);
        mc(0, 0, 0);
        adv();
        adv();
        run();
        chk("rst_ready", {31'd0, mc_ready}, 32'd0);
        adv();
        reset = 1'b1;

        // two queued entries, then reset mid-operation
        pw(1, 0, 0, 32'h11, 5'd3);
        mc(1, 32'hA1, 5'd9);
        run(); adv();
        mc(1, 32'hA2, 5'd10);
        run(); adv();
        mc(0, 0, 0);
        run();
        chk("fill2_cnt", 32'(fifo_count), 32'd2);
        adv();
        pw(0, 0, 0, 0, 0);
        reset = 1'b0;
        run();
        chk("inrst_we", {31'd0, rf_we}, 32'd0);
        chk("inrst_ready", {31'd0, mc_ready}, 32'd0);
        adv();
        reset = 1'b1;
        run();
        chk("post_cnt", 32'(fifo_count), 32'd0);
        chk("post_we", {31'd0, rf_we}, 32'd0);
        chk("post_ready", {31'd0, mc_ready}, 32'd1);
        chk("post_stall", {31'd0, pipe_stall}, 32'd0);
        adv();

        // pipeline writeback mux
        pw(1, 1, 32'hDEADBEEF, 32'h1, 5'd5);
        run();
        chk("ld_we", {31'd0, rf_we}, 32'd1);
        chk("ld_addr", {27'd0, rf_waddr}, 32'd5);
        chk("ld_data", rf_wdata, 32'hDEADBEEF);
        adv();
        pw(1, 0, 32'hDEADBEEF, 32'h1, 5'd5);
        run();
        chk("alu_data", rf_wdata, 32'h1);
        adv();

        // multi-cycle result into an idle pipeline
        pw(0, 0, 0, 0, 0);
        mc(1, 32'h1234, 5'd7);
        run();
        chk("mc_cnt0", 32'(fifo_count), 32'd0);
`ifdef WB_BYPASS_EN
        chk("byp_we", {31'd0, rf_we}, 32'd1);
        chk("byp_data", rf_wdata, 32'h1234);
`else
        chk("mc_we0", {31'd0, rf_we}, 32'd0);
`endif
        adv();
        mc(0, 0, 0);
        run();
`ifndef WB_BYPASS_EN
        chk("mc_we1", {31'd0, rf_we}, 32'd1);
        chk("mc_addr", {27'd0, rf_waddr}, 32'd7);
        chk("mc_data", rf_wdata, 32'h1234);
        chk("mc_cnt1", 32'(fifo_count), 32'd1);
`endif
        adv();
        run();
        chk("mc_cnt2", 32'(fifo_count), 32'd0);
        adv();

        // starvation: pipeline busy every cycle
        pw(1, 0, 0, 32'h55, 5'd3);
        mc(1, 32'hBEEF, 5'd12);
        run(); adv();
        mc(0, 0, 0);
        n = 0;
        while (n < 20) begin
            run();
            n++;
            if (pipe_stall) break;
            adv();
        end
        chk("stall_lat", 32'(n), 32'd6);
        adv();
        pw(1, 0, 0, 32'h77, 5'd4);
        run();
        chk("frc_addr", {27'd0, rf_waddr}, 32'd12);
        chk("frc_data", rf_wdata, 32'hBEEF);
        chk("frc_stall", {31'd0, pipe_stall}, 32'd0);
        adv();
        pw(0, 0, 0, 0, 0);
        run();
        chk("perr_hi", {31'd0, protocol_err}, 32'd1);
        adv();
        run();
        chk("perr_lo", {31'd0, protocol_err}, 32'd0);
        adv();

        // fill while pipeline busy, hold a third result
        pw(1, 0, 0, 32'h66, 5'd3);
        mc(1, 32'hC1, 5'd13);
        run(); adv();
        mc(1, 32'hC2, 5'd14);
        run(); adv();
        mc(1, 32'hC3, 5'd15);
        run();
        chk("full_rdy", {31'd0, mc_ready}, 32'd0);
        chk("full_cnt", 32'(fifo_count), 32'd2);
        adv();
        run(); adv();
        pw(0, 0, 0, 0, 0);
        run();
        chk("drain_a", {27'd0, rf_waddr}, 32'd13);
        adv();
        run();
        chk("drain_b", {27'd0, rf_waddr}, 32'd14);
        adv();
        mc(0, 0, 0);
        run();
        chk("drain_c", rf_wdata, 32'hC3);
        adv();
        run();
        chk("drain_cnt", 32'(fifo_count), 32'd0);
        adv();

        // destination r0
        pw(1, 0, 0, 32'h99, 5'd0);
        run();
        chk("r0_pipe", {31'd0, rf_we}, 32'd0);
        adv();
        pw(1, 0, 0, 32'h99, 5'd3);
        mc(1, 32'h77, 5'd0);
        run(); adv();
        pw(0, 0, 0, 0, 0);
        mc(0, 0, 0);
        run();
        chk("r0_fifo_we", {31'd0, rf_we}, 32'd0);
        chk("r0_fifo_cnt", 32'(fifo_count), 32'd1);
        adv();
        run();
        chk("r0_consumed", 32'(fifo_count), 32'd0);
        adv();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) != 0);
            if (m_forced) rw = ($urandom_range(0, 4) == 0);
            else          rw = ($urandom_range(0, 9) < 6);
            m2r   = $urandom_range(0, 1);
            rdat  = $urandom;
            res   = $urandom;
            pdst  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            mcv   = ($urandom_range(0, 2) == 0);
            mcd   = $urandom;
            mcdst = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            run();
            adv();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
